// File: rtl/key_event_arbiter.sv
// Round-robin arbiter that serializes one-cycle key presses onto a valid/ready
// event stream, with a post-event lockout gap and a saturating drop counter.
//
// state   | meaning
// S_IDLE  | nothing offered; grant next pending key if enabled
// S_OFFER | evt_valid high, holding evt_id until evt_ready
// S_GAP   | lockout after an accepted event, GAP_CYCLES long
module key_event_arbiter #(
  parameter int N_KEYS     = 4,
  parameter int ID_W       = 2,
  parameter int GAP_CYCLES = 50_000,
  parameter int GAP_W      = 16,
  parameter int DROP_W     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [N_KEYS-1:0] key_pulse,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [ID_W-1:0]   evt_id,
  output logic              evt_multi,
  output logic [N_KEYS-1:0] pending,
  input  logic              drop_clr,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int CNT_W = $clog2(N_KEYS + 1);
  localparam int SUM_W = DROP_W + CNT_W;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);
  localparam logic [ID_W:0]    N_EXT    = (ID_W + 1)'(N_KEYS);
  localparam logic [SUM_W-1:0] DROP_MAX = SUM_W'({DROP_W{1'b1}});

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_GAP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N_KEYS-1:0]   r_pending;
  logic [N_KEYS-1:0]   w_pending_nxt;
  logic [N_KEYS-1:0]   w_grant_vec;
  logic [N_KEYS-1:0]   w_drop_vec;
  logic [ID_W-1:0]     r_evt_id;
  logic [ID_W-1:0]     r_last_grant;
  logic [ID_W-1:0]     w_grant_id;
  logic                w_grant_found;
  logic                w_grant;
  logic [ID_W:0]       w_scan_idx;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [DROP_W-1:0]   r_drop_cnt;
  logic [CNT_W-1:0]    w_drop_n;
  logic [SUM_W-1:0]    w_drop_sum;

  // Scan starts one past the last grant and wraps, so every key gets a turn.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_id    = '0;
    w_scan_idx    = '0;
    for (int k = 1; k <= N_KEYS; k++) begin
      w_scan_idx = {1'b0, r_last_grant} + (ID_W + 1)'(k);
      if (w_scan_idx >= N_EXT) w_scan_idx = w_scan_idx - N_EXT;
      if (!w_grant_found && r_pending[w_scan_idx[ID_W-1:0]]) begin
        w_grant_found = 1'b1;
        w_grant_id    = w_scan_idx[ID_W-1:0];
      end
    end
  end

  assign w_grant     = (r_state == S_IDLE) && enable && w_grant_found;
  assign w_grant_vec = w_grant ? (N_KEYS'(1) << w_grant_id) : '0;

  // A pulse on the key being granted re-arms it as a fresh event, not a drop.
  always_comb begin
    w_pending_nxt = '0;
    w_drop_vec    = '0;
    if (enable) begin
      w_drop_vec    = key_pulse & r_pending & ~w_grant_vec;
      w_pending_nxt = (r_pending & ~w_grant_vec) | key_pulse;
    end
  end

  always_comb begin
    w_drop_n = '0;
    for (int i = 0; i < N_KEYS; i++) w_drop_n = w_drop_n + CNT_W'(w_drop_vec[i]);
  end

  assign w_drop_sum = SUM_W'(r_drop_cnt) + SUM_W'(w_drop_n);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending    <= '0;
      r_evt_id     <= '0;
      r_last_grant <= ID_W'(N_KEYS - 1);
      r_drop_cnt   <= '0;
      r_gap_cnt    <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_grant) begin
        r_evt_id     <= w_grant_id;
        r_last_grant <= w_grant_id;
      end
      if (drop_clr)                  r_drop_cnt <= '0;
      else if (w_drop_sum > DROP_MAX) r_drop_cnt <= '1;
      else                            r_drop_cnt <= w_drop_sum[DROP_W-1:0];
      if (r_state == S_GAP)
        r_gap_cnt <= (r_gap_cnt == GAP_LAST) ? '0 : r_gap_cnt + GAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_OFFER;
      S_OFFER: if (evt_ready) w_state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (r_gap_cnt == GAP_LAST) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // evt_valid decodes the state register so an async reset drops it at once.
  always_comb begin
    evt_valid = (r_state == S_OFFER);
    evt_multi = (r_state == S_OFFER) && (|r_pending);
    evt_id    = r_evt_id;
    pending   = r_pending;
    drop_cnt  = r_drop_cnt;
  end

endmodule
